mca_spectrum_accum: RTL and testbench

Histogram accumulator on the consuming side of the pulse-capture path. Each captured peak code from the ADC capture block increments one bin of an on-chip spectrum memory; a host-side read port retrieves bin counts. Sits between the ADC capture/clock block and the host interface, in the `clk` domain.

---
 rtl/mca_spectrum_accum.sv | 171 +++++++++++++++++
 tb/tb_mca_spectrum_accum.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mca_spectrum_accum.sv
`default_nettype none
// ============================================================================
// Module      : mca_spectrum_accum
// Description : Multichannel-analyser histogram accumulator. Every captured
//               peak code increments one bin of an on-chip spectrum memory
//               through a two-stage read-modify-write pipeline with
//               forwarding, so samples can arrive every cycle. A host read
//               port returns bin counts. A clear sweep zeroes the spectrum.
// Ports       : clk, rst_n          clock / async active-low reset
//               sample_valid/code   captured peak (code = bin index)
//               clear_start, busy   start clear sweep / sweep in progress
//               rd_req/addr         host read request (held until rd_ack)
//               rd_ack, rd_valid    request accepted / rd_data valid
//               rd_data             bin count (held until next rd_valid)
//               total_cnt           samples accepted since last clear
//               drop_cnt            samples discarded during clear (sat.)
// Revision    : 1.0 - initial release
// ============================================================================
module mca_spectrum_accum #(
    parameter int ADC_W = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] sample_code,
    input  logic             clear_start,
    output logic             busy,
    input  logic             rd_req,
    input  logic [ADC_W-1:0] rd_addr,
    output logic             rd_ack,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic [31:0]      total_cnt,
    output logic [15:0]      drop_cnt
);

    localparam int               c_DEPTH    = 1 << ADC_W;
    localparam logic [ADC_W-1:0] c_LAST_BIN = {ADC_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [0:0]       r_state;
    logic             r_clr_pend;     // clear requested while a write was in flight
    logic [ADC_W-1:0] r_sweep_addr;
    logic             r_s2_valid;
    logic [ADC_W-1:0] r_s2_code;
    logic             r_s2_fwd;       // stage 2 must use r_fwd_data instead of RAM
    logic [CNT_W-1:0] r_fwd_data;     // stage-2 write value of the previous cycle
    logic [CNT_W-1:0] r_ram_q;
    logic             r_rd_valid;
    logic             r_rd_fwd;
    logic [CNT_W-1:0] r_rd_hold;
    logic [31:0]      r_total;
    logic [15:0]      r_drop;
    logic [CNT_W-1:0] r_mem [c_DEPTH];

    logic             w_run;
    logic             w_accept;
    logic             w_rd_ack;
    logic             w_go_clear;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_wr_data;
    logic [CNT_W-1:0] w_rd_ram;
    logic             w_we;
    logic [ADC_W-1:0] w_wa;
    logic [CNT_W-1:0] w_wd;
    logic [ADC_W-1:0] w_ra;

    // The cycle between a clear request and the completion of the in-flight
    // write accepts nothing new, so no second RMW can start.
    assign w_run      = (r_state == c_ST_RUN) && !r_clr_pend;
    assign w_accept   = w_run && sample_valid;
    assign w_rd_ack   = w_run && rd_req && !sample_valid;
    assign w_go_clear = (r_state == c_ST_RUN) &&
                        (r_clr_pend || (clear_start && !w_accept));

    // Stage 2: RAM data is stale when the previous sample hit the same bin,
    // because that write lands on the same edge the read was sampled.
    assign w_base    = r_s2_fwd ? r_fwd_data : r_ram_q;
    assign w_wr_data = (w_base == c_CNT_MAX) ? w_base : w_base + 1'b1;
    assign w_rd_ram  = r_rd_fwd ? r_fwd_data : r_ram_q;

    assign w_we = (r_state == c_ST_CLEAR) || r_s2_valid;
    assign w_wa = (r_state == c_ST_CLEAR) ? r_sweep_addr : r_s2_code;
    assign w_wd = (r_state == c_ST_CLEAR) ? '0 : w_wr_data;
    assign w_ra = sample_valid ? sample_code : rd_addr;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wa] <= w_wd;
        end
        r_ram_q <= r_mem[w_ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_CLEAR;
            r_clr_pend   <= 1'b0;
            r_sweep_addr <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_code    <= '0;
            r_s2_fwd     <= 1'b0;
            r_fwd_data   <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_fwd     <= 1'b0;
            r_rd_hold    <= '0;
            r_total      <= '0;
            r_drop       <= '0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    if (clear_start) begin
                        r_sweep_addr <= '0;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + 1'b1;
                        if (r_sweep_addr == c_LAST_BIN) begin
                            r_state <= c_ST_RUN;
                        end
                    end
                end
                default: begin
                    if (r_clr_pend) begin
                        r_clr_pend   <= 1'b0;
                        r_state      <= c_ST_CLEAR;
                        r_sweep_addr <= '0;
                    end else if (clear_start) begin
                        if (w_accept) begin
                            r_clr_pend <= 1'b1;
                        end else begin
                            r_state      <= c_ST_CLEAR;
                            r_sweep_addr <= '0;
                        end
                    end
                end
            endcase

            r_s2_valid <= w_accept;
            r_s2_code  <= sample_code;
            r_s2_fwd   <= w_accept && r_s2_valid && (sample_code == r_s2_code);
            r_fwd_data <= w_wr_data;

            r_rd_valid <= w_rd_ack;
            r_rd_fwd   <= w_rd_ack && r_s2_valid && (rd_addr == r_s2_code);
            if (r_rd_valid) begin
                r_rd_hold <= w_rd_ram;
            end

            if ((r_state == c_ST_CLEAR) || w_go_clear) begin
                r_total <= '0;
            end else if (r_s2_valid) begin
                r_total <= r_total + 32'd1;
            end

            if (sample_valid && !w_run && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign busy      = (r_state == c_ST_CLEAR);
    assign rd_ack    = w_rd_ack;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_valid ? w_rd_ram : r_rd_hold;
    assign total_cnt = r_total;
    assign drop_cnt  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mca_spectrum_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_mca_spectrum_accum
// Description : Directed self-checking bench for mca_spectrum_accum. Main
//               instance uses CNT_W=16; a second instance uses CNT_W=4 to
//               exercise counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mca_spectrum_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid, clear_start, rd_req;
    logic [9:0]  sample_code, rd_addr;
    logic        busy, rd_ack, rd_valid;
    logic [15:0] rd_data;
    logic [31:0] total_cnt;
    logic [15:0] drop_cnt;

    logic        sv2, cs2, rq2;
    logic [9:0]  sc2, ra2;
    logic        busy2, ack2, val2;
    logic [3:0]  data2;
    logic [31:0] tot2;
    logic [15:0] drop2;

    int checks = 0;
    int errors = 0;

    mca_spectrum_accum #(.ADC_W(10), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(sample_valid), .sample_code(sample_code),
        .clear_start(clear_start), .busy(busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .total_cnt(total_cnt), .drop_cnt(drop_cnt)
    );

    mca_spectrum_accum #(.ADC_W(10), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(sv2), .sample_code(sc2),
        .clear_start(cs2), .busy(busy2),
        .rd_req(rq2), .rd_addr(ra2), .rd_ack(ack2),
        .rd_valid(val2), .rd_data(data2),
        .total_cnt(tot2), .drop_cnt(drop2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue a host read on instance 0 (inst=0) or the CNT_W=4 instance (inst=1).
    task automatic read_bin(input logic inst, input logic [9:0] addr, output logic [15:0] data);
        int   n;
        logic acked;
        if (inst) begin rq2 = 1'b1; ra2 = addr; end
        else      begin rd_req = 1'b1; rd_addr = addr; end
        n = 0;
        acked = 1'b0;
        while (!acked && n < 50) begin
            #1;
            acked = inst ? ack2 : rd_ack;
            if (!acked) begin
                step();
                n++;
            end
        end
        chk("rd_ack_seen", {31'd0, acked}, 32'd1);
        step();
        rd_req = 1'b0;
        rq2    = 1'b0;
        chk("rd_valid", {31'd0, (inst ? val2 : rd_valid)}, 32'd1);
        data = inst ? {12'd0, data2} : rd_data;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
    endtask

    initial begin
        logic [15:0] d;
        int          n;

        rst_n = 1'b0;
        sample_valid = 1'b0; sample_code = '0; clear_start = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        sv2 = 1'b0; sc2 = '0; cs2 = 1'b0; rq2 = 1'b0; ra2 = '0;
        step(); step();

        // Reset state; a pending read must not be acknowledged.
        rd_req = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_rd_ack", {31'd0, rd_ack}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_total", total_cnt, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        rd_req = 1'b0;
        step();

        // Initial sweep lasts exactly 1024 cycles.
        rst_n = 1'b1;
        count_busy(n);
        chk("sweep_len_init", n, 32'd1024);

        read_bin(1'b0, 10'd0, d);    chk("bin0_init", {16'd0, d}, 32'd0);
        read_bin(1'b0, 10'd511, d);  chk("bin511_init", {16'd0, d}, 32'd0);
        read_bin(1'b0, 10'd1023, d); chk("bin1023_init", {16'd0, d}, 32'd0);
        chk("total_init", total_cnt, 32'd0);

        // Single sample to bin 5.
        sample_valid = 1'b1; sample_code = 10'd5;
        step();
        sample_valid = 1'b0;
        read_bin(1'b0, 10'd5, d); chk("bin5", {16'd0, d}, 32'd1);
        read_bin(1'b0, 10'd4, d); chk("bin4", {16'd0, d}, 32'd0);
        read_bin(1'b0, 10'd6, d); chk("bin6", {16'd0, d}, 32'd0);
        chk("total_1", total_cnt, 32'd1);

        // 100 back-to-back samples to bin 1023, then 7/8/7.
        for (int i = 0; i < 100; i++) begin
            sample_valid = 1'b1; sample_code = 10'd1023;
            step();
        end
        sample_code = 10'd7; step();
        sample_code = 10'd8; step();
        sample_code = 10'd7; step();
        sample_valid = 1'b0;
        read_bin(1'b0, 10'd1023, d); chk("bin1023_100", {16'd0, d}, 32'd100);
        read_bin(1'b0, 10'd7, d);    chk("bin7", {16'd0, d}, 32'd2);
        read_bin(1'b0, 10'd8, d);    chk("bin8", {16'd0, d}, 32'd1);
        read_bin(1'b0, 10'd5, d);    chk("bin5_kept", {16'd0, d}, 32'd1);
        chk("total_104", total_cnt, 32'd104);   // 1 earlier + 103

        // CNT_W=4 instance: 20 samples to bin 0 saturate at 15.
        for (int i = 0; i < 20; i++) begin
            sv2 = 1'b1; sc2 = 10'd0;
            step();
        end
        sv2 = 1'b0;
        read_bin(1'b1, 10'd0, d); chk("sat_bin0", {16'd0, d}, 32'd15);
        chk("sat_total", tot2, 32'd20);

        // Read of bin 9 held while three samples to bin 9 stream.
        rd_req = 1'b1; rd_addr = 10'd9;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1; sample_code = 10'd9;
            #1;
            chk("rd_ack_blocked", {31'd0, rd_ack}, 32'd0);
            step();
        end
        sample_valid = 1'b0;
        #1;
        chk("rd_ack_free", {31'd0, rd_ack}, 32'd1);
        step();
        rd_req = 1'b0;
        chk("rd_valid_9", {31'd0, rd_valid}, 32'd1);
        chk("rd_data_9", {16'd0, rd_data}, 32'd3);
        step();
        chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
        chk("rd_data_hold", {16'd0, rd_data}, 32'd3);
        chk("total_107", total_cnt, 32'd107);

        // Bin 3 to 10, then clear with 4 samples dropped during the sweep.
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1'b1; sample_code = 10'd3;
            step();
        end
        sample_valid = 1'b0;
        read_bin(1'b0, 10'd3, d); chk("bin3_10", {16'd0, d}, 32'd10);
        chk("total_117", total_cnt, 32'd117);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        chk("total_clr", total_cnt, 32'd0);
        n = 0;
        while (busy && n < 3000) begin
            sample_valid = (n >= 2 && n < 6);
            sample_code  = 10'd3;
            step();
            n++;
        end
        sample_valid = 1'b0;
        chk("sweep_len_clr", n, 32'd1024);
        chk("drop_4", {16'd0, drop_cnt}, 32'd4);
        read_bin(1'b0, 10'd3, d); chk("bin3_cleared", {16'd0, d}, 32'd0);
        read_bin(1'b0, 10'd9, d); chk("bin9_cleared", {16'd0, d}, 32'd0);
        chk("total_after_clr", total_cnt, 32'd0);

        // Clear requested together with a sample: busy rises one cycle later.
        sample_valid = 1'b1; sample_code = 10'd3; clear_start = 1'b1;
        step();
        sample_valid = 1'b0; clear_start = 1'b0;
        chk("busy_pend", {31'd0, busy}, 32'd0);
        step();
        chk("busy_late", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 100; i++) step();

        // Reset mid-sweep restarts a full sweep and zeroes drop_cnt.
        rst_n = 1'b0;
        #1;
        chk("rst_mid_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        step(); step();
        rst_n = 1'b1;
        count_busy(n);
        chk("sweep_len_rst", n, 32'd1024);
        read_bin(1'b0, 10'd3, d); chk("bin3_after_rst", {16'd0, d}, 32'd0);
        chk("total_after_rst", total_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
